// File: rtl/ccw_output_arbiter_pkg.sv
// Shared constants for the ring-router output-port controllers: flit width,
// requester indices and virtual-channel phase encodings.
package ccw_output_arbiter_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int NREQ       = 3;

  localparam int REQ_CW  = 0;
  localparam int REQ_CCW = 1;
  localparam int REQ_PE  = 2;

  localparam logic PH_EVEN = 1'b0;
  localparam logic PH_ODD  = 1'b1;

endpackage

// File: rtl/ccw_output_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting the search at the
// stored pointer; the pointer moves past the winner whenever a grant is issued.
module rr_arbiter
  import ccw_output_arbiter_pkg::*;
#(
  parameter int N = NREQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    sum   = '0;
    idx   = '0;
    found = 1'b0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        sum = {1'b0, ptr_q} + (PW + 1)'(k);
        if (sum >= (PW + 1)'(N)) sum = sum - (PW + 1)'(N);
        idx = sum[PW-1:0];
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          ptr_d    = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ccw_output_arbiter.sv
// ccw outbound link controller: per-VC round-robin load into a one-flit
// buffer, with even/odd VCs alternating load and send under polarity.
module ccw_output_arbiter
  import ccw_output_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = ccw_output_arbiter_pkg::DATA_WIDTH,
  parameter int NREQ       = ccw_output_arbiter_pkg::NREQ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       polarity,
  input  logic [NREQ-1:0]            req_even,
  input  logic [NREQ-1:0]            req_odd,
  input  logic [NREQ*DATA_WIDTH-1:0] din_even,
  input  logic [NREQ*DATA_WIDTH-1:0] din_odd,
  output logic [NREQ-1:0]            gnt_even,
  output logic [NREQ-1:0]            gnt_odd,
  input  logic                       ro,
  output logic                       so,
  output logic [DATA_WIDTH-1:0]      dout
);

  logic                  full_even_q, full_even_d;
  logic                  full_odd_q, full_odd_d;
  logic [DATA_WIDTH-1:0] buf_even_q, buf_even_d;
  logic [DATA_WIDTH-1:0] buf_odd_q, buf_odd_d;
  logic                  en_even, en_odd;
  logic                  send_even, send_odd;
  logic [DATA_WIDTH-1:0] win_even, win_odd;

  // Grant is suppressed while rst is high so nothing is offered mid-reset.
  assign en_even = !rst && (polarity == PH_EVEN) && !full_even_q;
  assign en_odd  = !rst && (polarity == PH_ODD)  && !full_odd_q;

  rr_arbiter #(.N(NREQ)) u_arb_even (
    .clk (clk),
    .rst (rst),
    .en  (en_even),
    .req (req_even),
    .gnt (gnt_even)
  );

  rr_arbiter #(.N(NREQ)) u_arb_odd (
    .clk (clk),
    .rst (rst),
    .en  (en_odd),
    .req (req_odd),
    .gnt (gnt_odd)
  );

  // The VC that is not loading this cycle is the one allowed to send.
  assign send_even = !rst && (polarity == PH_ODD)  && full_even_q && ro;
  assign send_odd  = !rst && (polarity == PH_EVEN) && full_odd_q  && ro;
  assign so        = send_even || send_odd;
  assign dout      = send_even ? buf_even_q : (send_odd ? buf_odd_q : '0);

  always_comb begin
    win_even = '0;
    win_odd  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_even[i]) win_even = din_even[i*DATA_WIDTH +: DATA_WIDTH];
      if (gnt_odd[i])  win_odd  = din_odd[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    full_even_d = full_even_q;
    full_odd_d  = full_odd_q;
    buf_even_d  = buf_even_q;
    buf_odd_d   = buf_odd_q;
    if (|gnt_even) begin
      full_even_d = 1'b1;
      buf_even_d  = win_even;
    end else if (send_even) begin
      full_even_d = 1'b0;
    end
    if (|gnt_odd) begin
      full_odd_d = 1'b1;
      buf_odd_d  = win_odd;
    end else if (send_odd) begin
      full_odd_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_even_q <= 1'b0;
      full_odd_q  <= 1'b0;
      buf_even_q  <= '0;
      buf_odd_q   <= '0;
    end else begin
      full_even_q <= full_even_d;
      full_odd_q  <= full_odd_d;
      buf_even_q  <= buf_even_d;
      buf_odd_q   <= buf_odd_d;
    end
  end

endmodule

// File: tb/tb_ccw_output_arbiter.sv
// Bench for ccw_output_arbiter: directed scenarios plus random traffic,
// checked each cycle against a behavioural model of the link controller.
module tb_ccw_output_arbiter;

  localparam int W = 64;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           polarity = 1'b0;
  logic [N-1:0]   req_even = '0, req_odd = '0;
  logic [N*W-1:0] din_even = '0, din_odd = '0;
  logic [N-1:0]   gnt_even, gnt_odd;
  logic           ro = 1'b0;
  logic           so;
  logic [W-1:0]   dout;

  ccw_output_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .polarity (polarity),
    .req_even (req_even),
    .req_odd  (req_odd),
    .din_even (din_even),
    .din_odd  (din_odd),
    .gnt_even (gnt_even),
    .gnt_odd  (gnt_odd),
    .ro       (ro),
    .so       (so),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  // Model state: index 0 = even VC, 1 = odd VC.
  bit         m_full[2];
  logic [W-1:0] m_buf[2];
  int         m_ptr[2];
  logic [N-1:0] e_gnt[2];
  logic       e_so;
  logic [W-1:0] e_dout;

  int n_chk = 0;
  int n_pass = 0;

  function automatic logic [N-1:0] pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j]) return N'(1) << j;
    end
    return '0;
  endfunction

  function automatic int onehot_idx(logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_comb();
    int lv, sv;
    e_gnt[0] = '0;
    e_gnt[1] = '0;
    e_so     = 1'b0;
    e_dout   = '0;
    if (!rst) begin
      lv = polarity ? 1 : 0;
      sv = 1 - lv;
      if (!m_full[lv]) e_gnt[lv] = pick(lv == 0 ? req_even : req_odd, m_ptr[lv]);
      e_so   = m_full[sv] && ro;
      e_dout = e_so ? m_buf[sv] : '0;
    end
  endtask

  // Evaluate the model for the current inputs and compare at the falling edge.
  task automatic settle();
    model_comb();
    @(negedge clk);
    chk("gnt_even", W'(gnt_even), W'(e_gnt[0]));
    chk("gnt_odd",  W'(gnt_odd),  W'(e_gnt[1]));
    chk("so",       W'(so),       W'(e_so));
    chk("dout",     dout,         e_dout);
  endtask

  // Clock edge: update model, requesters drop granted requests, phase toggles.
  task automatic advance();
    int w;
    @(posedge clk);
    if (rst) begin
      m_full[0] = 0; m_full[1] = 0;
      m_buf[0] = '0; m_buf[1] = '0;
      m_ptr[0] = 0;  m_ptr[1] = 0;
    end else begin
      if (e_so) m_full[polarity ? 0 : 1] = 0;
      if (e_gnt[0] != 0) begin
        w = onehot_idx(e_gnt[0]);
        m_buf[0] = din_even[w*W +: W]; m_full[0] = 1; m_ptr[0] = (w + 1) % N;
      end
      if (e_gnt[1] != 0) begin
        w = onehot_idx(e_gnt[1]);
        m_buf[1] = din_odd[w*W +: W]; m_full[1] = 1; m_ptr[1] = (w + 1) % N;
      end
    end
    #1;
    req_even = req_even & ~e_gnt[0];
    req_odd  = req_odd  & ~e_gnt[1];
    polarity = ~polarity;
  endtask

  task automatic set_de(int i, logic [W-1:0] v);
    din_even[i*W +: W] = v;
  endtask

  task automatic set_do(int i, logic [W-1:0] v);
    din_odd[i*W +: W] = v;
  endtask

  initial begin
    #1;
    // Reset held 3 cycles with requests and ready asserted.
    rst = 1'b1; req_even = 3'b111; req_odd = 3'b111; ro = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("rst_gnt_even", W'(gnt_even), '0);
      chk("rst_gnt_odd",  W'(gnt_odd),  '0);
      chk("rst_so",       W'(so),       '0);
      chk("rst_dout",     dout,         '0);
      advance();
    end
    rst = 1'b0; polarity = 1'b0;
    req_even = 3'b010; req_odd = '0; set_de(1, 64'hA5);
    for (int i = 0; i < N; i++) set_do(i, 64'h100 + W'(i));

    // k0: even load from requester 1.
    settle(); chk("single_gnt", W'(gnt_even), 64'h2); advance();
    // k1: even sends; odd round-robin begins at pointer 0.
    req_odd = 3'b111;
    settle(); chk("single_so", W'(so), 64'h1); chk("single_dout", dout, 64'hA5);
    chk("rr_gnt0", W'(gnt_odd), 64'h1); advance();
    // k2..k7: odd grants rotate 1, 2, 0 with requesters re-raising.
    req_odd = 3'b111; settle(); chk("rr_send0", dout, 64'h100); advance();
    settle(); chk("rr_gnt1", W'(gnt_odd), 64'h2); advance();
    req_odd = 3'b111; settle(); advance();
    settle(); chk("rr_gnt2", W'(gnt_odd), 64'h4); advance();
    req_odd = 3'b111; settle(); advance();
    settle(); chk("rr_gnt3", W'(gnt_odd), 64'h1); advance();
    req_odd = '0;

    // k8..k15: backpressure on the even VC.
    req_even = 3'b001; set_de(0, 64'h11);
    settle(); chk("bp_load", W'(gnt_even), 64'h1); advance();
    ro = 1'b0; req_even = 3'b001; set_de(0, 64'h44);
    for (int c = 0; c < 4; c++) begin
      settle(); chk("bp_so", W'(so), 64'h0); chk("bp_gnt", W'(gnt_even), 64'h0); advance();
    end
    ro = 1'b1;
    settle(); chk("bp_release", dout, 64'h11); chk("bp_rel_so", W'(so), 64'h1); advance();
    settle(); chk("bp_regrant", W'(gnt_even), 64'h1); advance();
    settle(); chk("bp_second", dout, 64'h44); advance();

    // k16..k18: interleaved VCs.
    req_even = 3'b100; set_de(2, 64'h22);
    settle(); chk("il_gnt_e", W'(gnt_even), 64'h4); advance();
    req_odd = 3'b001; set_do(0, 64'h33); req_even = 3'b100;
    settle(); chk("il_dout_e", dout, 64'h22); chk("il_gnt_o", W'(gnt_odd), 64'h1); advance();
    settle(); chk("il_dout_o", dout, 64'h33); advance();
    settle(); advance();

    // Reset with both buffers full.
    ro = 1'b0; req_even = 3'b010; req_odd = '0;
    set_de(1, 64'hBAD0); set_do(1, 64'hBAD1);
    settle(); advance();
    req_odd = 3'b010;
    settle(); advance();
    rst = 1'b1; req_even = 3'b111; ro = 1'b1;
    settle(); chk("mr_so", W'(so), 64'h0); chk("mr_gnt", W'(gnt_even), 64'h0); advance();
    rst = 1'b0; req_odd = 3'b111; set_do(0, 64'h55);
    settle(); chk("mr_nostale", W'(so), 64'h0); chk("mr_ptr_o", W'(gnt_odd), 64'h1); advance();
    settle(); chk("mr_ptr_e", W'(gnt_even), 64'h1); chk("mr_fresh", dout, 64'h55); advance();

    // Random traffic with random backpressure and occasional reset.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_even[i] && ($urandom % 3 == 0)) begin
          req_even[i] = 1'b1; set_de(i, {$urandom, $urandom});
        end
        if (!req_odd[i] && ($urandom % 3 == 0)) begin
          req_odd[i] = 1'b1; set_do(i, {$urandom, $urandom});
        end
      end
      ro  = ($urandom % 4) != 0;
      rst = ($urandom % 150) == 0;
      settle();
      advance();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
